mem_arbiter: RTL and testbench

Two-port round-robin arbiter and initialisation sequencer for the shared 4096×16 synchronous-read `memory` block. After reset it sweeps every word to a known pattern. It then shares the single memory port between two requesters at one access per cycle. Read data is returned on each requester's own `rvalid`/`rdata`. It sits directly in front of `memory` and drives all of its inputs except `clk`.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 29 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and default sizing for the mem_arbiter slice
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   localparam int NPORTS        = 2;
   localparam int DEF_ADDRWIDTH = 12;
   localparam int DEF_DATAWIDTH = 16;
   localparam int DEF_WORDS     = 4096;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2  : combinational 2-way round-robin, one-hot grant; pointer kept by parent
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [NPORTS-1:0] req,
   input  logic              last,
   output logic [NPORTS-1:0] gnt
);

   // On contention the port that did not win last time is served.
   always_comb begin
      gnt = '0;
      if (req[0] && req[1]) begin
         if (last) begin
            gnt[0] = 1'b1;
         end else begin
            gnt[1] = 1'b1;
         end
      end else begin
         gnt = req;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : init sweep + 2-port round-robin front end for a sync-read memory
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDRWIDTH = DEF_ADDRWIDTH,
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int WORDS     = DEF_WORDS,
   parameter int INIT_EN   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADDRWIDTH-1:0] addr0,
   input  logic [ADDRWIDTH-1:0] addr1,
   input  logic [DATAWIDTH-1:0] wdata0,
   input  logic [DATAWIDTH-1:0] wdata1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 rvalid0,
   output logic                 rvalid1,
   output logic [DATAWIDTH-1:0] rdata0,
   output logic [DATAWIDTH-1:0] rdata1,
   output logic                 busy,
   output logic [ADDRWIDTH-1:0] mem_addr,
   output logic [DATAWIDTH-1:0] mem_d,
   output logic                 mem_load,
   input  logic [DATAWIDTH-1:0] mem_q
);

   localparam state_e               RESET_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;
   localparam logic [ADDRWIDTH-1:0] CNT_MAX     = ADDRWIDTH'(WORDS - 1);

   if (WORDS != (1 << ADDRWIDTH)) begin : g_bad_depth
      $error("mem_arbiter: WORDS must equal 2**ADDRWIDTH");
   end

   state_e                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   cnt_q, cnt_d;
   logic                   last_q, last_d;
   logic                   last_vld_q, last_vld_d;
   logic                   rd_pend_q, rd_pend_d;
   logic                   rd_tag_q, rd_tag_d;
   logic                   rvalid0_q, rvalid1_q;
   logic [ADDRWIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATAWIDTH-1:0]   mem_d_q, mem_d_d;
   logic                   mem_load_q, mem_load_d;

   logic [NPORTS-1:0]      arb_req;
   logic [NPORTS-1:0]      arb_gnt;
   logic                   last_eff;
   logic                   xfer;
   logic                   sel;
   logic                   sel_we;

   // Grants are gated by rst_n so nothing is offered while reset is held.
   assign arb_req  = (rst_n && (state_q == S_RUN)) ? {req1, req0} : '0;
   // Until the first transfer, act as if port 1 went last so port 0 wins first.
   assign last_eff = last_vld_q ? last_q : 1'b1;

   rr_arb2 u_rr_arb2 (
      .req  (arb_req),
      .last (last_eff),
      .gnt  (arb_gnt)
   );

   assign gnt0   = arb_gnt[0];
   assign gnt1   = arb_gnt[1];
   assign xfer   = |arb_gnt;
   assign sel    = arb_gnt[1];
   assign sel_we = sel ? we1 : we0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      last_vld_d = last_vld_q;
      rd_pend_d  = 1'b0;
      rd_tag_d   = rd_tag_q;
      mem_addr_d = mem_addr_q;
      mem_d_d    = mem_d_q;
      mem_load_d = 1'b0;
      unique case (state_q)
         S_INIT: begin
            mem_addr_d = cnt_q;
            mem_d_d    = DATAWIDTH'(cnt_q);
            mem_load_d = 1'b1;
            if (cnt_q == CNT_MAX) begin
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + ADDRWIDTH'(1);
            end
         end
         S_RUN: begin
            if (xfer) begin
               mem_addr_d = sel ? addr1 : addr0;
               mem_d_d    = sel ? wdata1 : wdata0;
               mem_load_d = sel_we;
               rd_pend_d  = !sel_we;
               rd_tag_d   = sel;
               last_d     = sel;
               last_vld_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         last_vld_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_tag_q   <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_d_q    <= '0;
         mem_load_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         rd_pend_q  <= rd_pend_d;
         rd_tag_q   <= rd_tag_d;
         rvalid0_q  <= rd_pend_q && !rd_tag_q;
         rvalid1_q  <= rd_pend_q && rd_tag_q;
         mem_addr_q <= mem_addr_d;
         mem_d_q    <= mem_d_d;
         mem_load_q <= mem_load_d;
      end
   end

   assign busy     = (state_q == S_INIT);
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = mem_q;
   assign rdata1   = mem_q;
   assign mem_addr = mem_addr_q;
   assign mem_d    = mem_d_q;
   assign mem_load = mem_load_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed vector bench for mem_arbiter with a 4096x16 memory model
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [11:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_load;
   logic [15:0] rdata0, rdata1, mem_d, mem_q;
   logic [11:0] mem_addr;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        r0, w0;
      logic [11:0] a0;
      logic [15:0] d0;
      logic        r1, w1;
      logic [11:0] a1;
      logic [15:0] d1;
      logic        eg0, eg1, ev0, ev1;
      logic [15:0] erd;
   } vec_t;

   vec_t vecs[$];

   mem_arbiter #(
      .ADDRWIDTH (12),
      .DATAWIDTH (16),
      .WORDS     (4096),
      .INIT_EN   (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .rvalid0  (rvalid0),
      .rvalid1  (rvalid1),
      .rdata0   (rdata0),
      .rdata1   (rdata1),
      .busy     (busy),
      .mem_addr (mem_addr),
      .mem_d    (mem_d),
      .mem_load (mem_load),
      .mem_q    (mem_q)
   );

   // Synchronous-read memory that reads before it writes.
   logic [15:0] mem [0:4095];
   always @(posedge clk) begin
      mem_q <= mem[mem_addr];
      if (mem_load) mem[mem_addr] <= mem_d;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic r0, w0, input logic [11:0] a0, input logic [15:0] d0,
                              input logic r1, w1, input logic [11:0] a1, input logic [15:0] d1,
                              input logic eg0, eg1, ev0, ev1, input logic [15:0] erd);
      vec_t t;
      t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
      t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
      t.eg0 = eg0; t.eg1 = eg1; t.ev0 = ev0; t.ev1 = ev1; t.erd = erd;
      return t;
   endfunction

   function automatic vec_t idle(input logic ev0, ev1, input logic [15:0] erd);
      return v(0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0, 0, ev0, ev1, erd);
   endfunction

   task automatic drive(input vec_t t);
      req0 = t.r0; we0 = t.w0; addr0 = t.a0; wdata0 = t.d0;
      req1 = t.r1; we1 = t.w1; addr1 = t.a1; wdata1 = t.d1;
   endtask

   initial begin
      int  n;
      logic gnt_in_init;

      // Both ports read continuously: 0,1,0,1 and data routed per port.
      vecs.push_back(v(1, 0, 12'h000, 0, 1, 0, 12'h7FF, 0, 1, 0, 0, 0, 16'h0000));
      vecs.push_back(v(1, 0, 12'hFFF, 0, 1, 0, 12'h7FF, 0, 0, 1, 0, 0, 16'h0000));
      vecs.push_back(v(1, 0, 12'hFFF, 0, 1, 0, 12'h001, 0, 1, 0, 1, 0, 16'h0000));
      vecs.push_back(v(0, 0, 12'h000, 0, 1, 0, 12'h001, 0, 0, 1, 0, 1, 16'h07FF));
      vecs.push_back(idle(1, 0, 16'h0FFF));
      vecs.push_back(idle(0, 1, 16'h0001));
      // Port 0 write then read-back.
      vecs.push_back(v(1, 1, 12'h123, 16'hABCD, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 0, 12'h123, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(idle(0, 0, 0));
      vecs.push_back(idle(1, 0, 16'hABCD));
      // Port 1 alone for 10 cycles, then port 0 joins and wins.
      for (int k = 0; k < 10; k++)
         vecs.push_back(v(0, 0, 0, 0, 1, 0, 12'(12'h020 + k), 0, 0, 1, 0, k >= 2, 16'(16'h0020 + k - 2)));
      vecs.push_back(v(1, 0, 12'h030, 0, 1, 0, 12'h02A, 0, 1, 0, 0, 1, 16'h0028));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 12'h02A, 0, 0, 1, 0, 1, 16'h0029));
      vecs.push_back(idle(1, 0, 16'h0030));
      vecs.push_back(idle(0, 1, 16'h002A));
      // Write then read on consecutive edges: read sees new data.
      vecs.push_back(v(1, 1, 12'h010, 16'h5555, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 12'h010, 0, 0, 1, 0, 0, 0));
      vecs.push_back(idle(0, 0, 0));
      vecs.push_back(idle(0, 1, 16'h5555));
      // Read then write on consecutive edges: read sees old data.
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 12'h040, 0, 0, 1, 0, 0, 0));
      vecs.push_back(v(1, 1, 12'h040, 16'h1234, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(idle(0, 1, 16'h0040));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 12'h040, 0, 0, 1, 0, 0, 0));
      vecs.push_back(idle(0, 0, 0));
      vecs.push_back(idle(0, 1, 16'h1234));
      // Port 1 loses arbitration then withdraws: its write must never land.
      vecs.push_back(v(1, 0, 12'h050, 0, 1, 1, 12'h050, 16'h9999, 1, 0, 0, 0, 0));
      vecs.push_back(idle(0, 0, 0));
      vecs.push_back(idle(1, 0, 16'h0050));
      vecs.push_back(v(1, 0, 12'h050, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(idle(0, 0, 0));
      vecs.push_back(idle(1, 0, 16'h0050));

      // Reset held with both ports requesting.
      rst_n = 1'b0;
      drive(idle(0, 0, 0));
      req0 = 1'b1; req1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",      {gnt1, gnt0}, 2'b00);
      check("rst_busy",     busy, 1'b1);
      check("rst_mem_load", mem_load, 1'b0);
      check("rst_mem_addr", mem_addr, 12'h000);
      check("rst_mem_d",    mem_d, 16'h0000);
      check("rst_rvalid",   {rvalid1, rvalid0}, 2'b00);

      // Init sweep: count edges until busy falls.
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      gnt_in_init = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            check("init_first_addr", mem_addr, 12'h000);
            check("init_first_d",    mem_d, 16'h0000);
            check("init_first_load", mem_load, 1'b1);
         end
         if (busy && (gnt0 || gnt1)) gnt_in_init = 1'b1;
      end while (busy && n < 5000);
      check("init_cycles",     n, 4096);
      check("init_gnt_seen",   gnt_in_init, 1'b0);
      check("init_last_addr",  mem_addr, 12'hFFF);
      check("init_last_d",     mem_d, 16'h0FFF);
      check("init_last_load",  mem_load, 1'b1);

      // Vector table, one cycle each.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #2;
         check($sformatf("v%0d_gnt", i),    {gnt1, gnt0}, {vecs[i].eg1, vecs[i].eg0});
         check($sformatf("v%0d_rvalid", i), {rvalid1, rvalid0}, {vecs[i].ev1, vecs[i].ev0});
         check($sformatf("v%0d_busy", i),   busy, 1'b0);
         if (vecs[i].ev0) check($sformatf("v%0d_rdata0", i), rdata0, vecs[i].erd);
         if (vecs[i].ev1) check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].erd);
         @(posedge clk);
         #1;
      end

      // Reset one cycle after a write grant, with a read return in flight.
      drive(idle(0, 0, 0));
      req1 = 1'b1; addr1 = 12'h070;
      #2 check("mr_read_gnt1", gnt1, 1'b1);
      @(posedge clk); #1;
      drive(idle(0, 0, 0));
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h060; wdata0 = 16'h7777;
      #2 check("mr_write_gnt0", gnt0, 1'b1);
      @(posedge clk); #1;
      drive(idle(0, 0, 0));
      check("mr_load_before", mem_load, 1'b1);
      check("mr_rv1_before",  rvalid1, 1'b1);
      check("mr_rd1_before",  rdata1, 16'h0070);
      #2 rst_n = 1'b0;
      #1;
      check("mr_load_async",  mem_load, 1'b0);
      check("mr_rvalid_drop", {rvalid1, rvalid0}, 2'b00);
      check("mr_busy",        busy, 1'b1);
      check("mr_addr_reset",  mem_addr, 12'h000);
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check($sformatf("mr_hold%0d_gnt", k),    {gnt1, gnt0}, 2'b00);
         check($sformatf("mr_hold%0d_rvalid", k), {rvalid1, rvalid0}, 2'b00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      check("mr_sweep0_addr", mem_addr, 12'h000);
      check("mr_sweep0_d",    mem_d, 16'h0000);
      check("mr_sweep0_load", mem_load, 1'b1);
      check("mr_no_partial",  mem[12'h060], 16'h0060);
      check("mr_rvalid_post", {rvalid1, rvalid0}, 2'b00);
      @(posedge clk); #1;
      check("mr_sweep1_addr", mem_addr, 12'h001);
      check("mr_sweep1_d",    mem_d, 16'h0001);
      check("mr_busy_post",   busy, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
